// File: rtl/bit_sync_filt.sv
// bit_sync_filt: per-channel multi-flop synchroniser followed by a persistence filter.
// Defining BIT_SYNC_FILT_EDGE_EN compiles in the rise/fall/chg strobe logic.
module bit_sync_filt #(
  parameter int   WIDTH    = 1,
  parameter int   STAGES   = 2,
  parameter int   FILT_CNT = 4,
  parameter logic INIT_VAL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] bit_i,
  output logic [WIDTH-1:0] bit_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             chg_o
);

  localparam int               CW       = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(FILT_CNT - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] INIT_VEC = {WIDTH{INIT_VAL}};

  // The first two stages are the metastability flops; keep them adjacent in placement.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta0_q;
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] meta1_q;
  logic [WIDTH-1:0] meta0_d;
  logic [WIDTH-1:0] meta1_d;
  logic [WIDTH-1:0] s;

  always_comb begin
    meta0_d = bit_i;
    meta1_d = meta0_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta0_q <= INIT_VEC;
      meta1_q <= INIT_VEC;
    end else begin
      meta0_q <= meta0_d;
      meta1_q <= meta1_d;
    end
  end

  if (STAGES > 2) begin : g_tail
    localparam int NT = STAGES - 2;
    logic [WIDTH-1:0] tail_q [NT];
    logic [WIDTH-1:0] tail_d [NT];

    always_comb begin
      tail_d[0] = meta1_q;
      for (int k = 1; k < NT; k++) begin
        tail_d[k] = tail_q[k-1];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int k = 0; k < NT; k++) begin
          tail_q[k] <= INIT_VEC;
        end
      end else begin
        for (int k = 0; k < NT; k++) begin
          tail_q[k] <= tail_d[k];
        end
      end
    end

    assign s = tail_q[NT-1];
  end else begin : g_no_tail
    assign s = meta1_q;
  end

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] bit_q;
  logic [WIDTH-1:0] bit_d;

  // A new level is taken only after it has disagreed with bit_q for FILT_CNT
  // consecutive cycles; any agreement in between restarts the count.
  always_comb begin
    bit_d = bit_q;
    for (int n = 0; n < WIDTH; n++) begin
      cnt_d[n] = '0;
      if (s[n] != bit_q[n]) begin
        if (cnt_q[n] == CNT_LAST) begin
          bit_d[n] = s[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_q <= INIT_VEC;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      bit_q <= bit_d;
      for (int n = 0; n < WIDTH; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  assign bit_o = bit_q;

`ifdef BIT_SYNC_FILT_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;

  // Strobes register alongside bit_q so they coincide with the first new-level cycle.
  always_comb begin
    rise_d = bit_d & ~bit_q;
    fall_d = ~bit_d & bit_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign chg_o  = |(rise_q | fall_q);
`else
  assign rise_o = '0;
  assign fall_o = '0;
  assign chg_o  = 1'b0;
`endif

endmodule

// File: tb/tb_bit_sync_filt.sv
// Self-checking bench for bit_sync_filt: a sample-history model feeds an expectation
// queue that is popped and compared every cycle, plus latency/strobe-count checks.
`timescale 1ns/1ps
module tb_bit_sync_filt;

  localparam int W  = 4;
  localparam int ST = 2;
  localparam int FC = 3;
  localparam int HL = ST + FC;
`ifdef BIT_SYNC_FILT_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [W-1:0] bit_i = '0;
  logic [W-1:0] bit_o;
  logic [W-1:0] rise_o;
  logic [W-1:0] fall_o;
  logic         chg_o;

  always #5 clk_i = ~clk_i;

  bit_sync_filt #(
    .WIDTH    (W),
    .STAGES   (ST),
    .FILT_CNT (FC),
    .INIT_VAL (1'b0)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bit_i  (bit_i),
    .bit_o  (bit_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .chg_o  (chg_o)
  );

  typedef struct packed {
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [W-1:0] f;
    logic         c;
  } exp_t;

  exp_t         sb_q [$];
  logic [W-1:0] hist [HL];
  logic [W-1:0] m_out;
  int           checks = 0;
  int           errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < HL; i++) hist[i] = '0;
    m_out = '0;
  endtask

  // hist[HL-1] is the sample taken at this edge; the filter at this edge sees the
  // samples taken ST..ST+FC-1 edges earlier, i.e. hist[0..FC-1].
  task automatic model_edge(input logic rst_now, input logic [W-1:0] v);
    exp_t         e;
    logic [W-1:0] acc;
    e = '0;
    if (rst_now) begin
      model_reset();
    end else begin
      for (int i = 0; i < HL-1; i++) hist[i] = hist[i+1];
      hist[HL-1] = v;
      acc = '1;
      for (int i = 0; i < FC; i++) acc &= hist[i] ^ m_out;
      e.b = m_out ^ acc;
      e.r = EDGE_EN ? (acc & ~m_out) : '0;
      e.f = EDGE_EN ? (acc & m_out) : '0;
      e.c = |(e.r | e.f);
      m_out = e.b;
    end
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_val("bit_o",  32'(bit_o),  32'(e.b));
    check_val("rise_o", 32'(rise_o), 32'(e.r));
    check_val("fall_o", 32'(fall_o), 32'(e.f));
    check_val("chg_o",  32'(chg_o),  32'(e.c));
  endtask

  task automatic cyc(input logic [W-1:0] v);
    bit_i = v;
    @(posedge clk_i);
    model_edge(rst_i, v);
    #1;
    sb_compare();
  endtask

  int first;
  int n_rise;
  int n_fall;
  int n_high;

  initial begin
    model_reset();

    // reset held with inputs high, then released with inputs returning low
    for (int i = 0; i < 10; i++) cyc(4'hF);
    @(negedge clk_i);
    rst_i  = 1'b0;
    n_rise = 0;
    n_fall = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(4'h0);
      if (rise_o != 0) n_rise++;
      if (fall_o != 0) n_fall++;
    end
    check_val("rel_rise_cnt", 32'(n_rise), 32'd0);
    check_val("rel_fall_cnt", 32'(n_fall), 32'd0);

    // step 0 -> 5
    first  = -1;
    n_rise = 0;
    for (int e = 0; e < 10; e++) begin
      cyc(4'h5);
      if (first < 0 && bit_o == 4'h5) first = e;
      if (rise_o == 4'h5) n_rise++;
    end
    check_val("step_latency", 32'(first), 32'd4);
    check_val("step_rise_cnt", 32'(n_rise), 32'(EDGE_EN));

    // fall 5 -> 0
    first  = -1;
    n_rise = 0;
    n_fall = 0;
    for (int e = 0; e < 10; e++) begin
      cyc(4'h0);
      if (first < 0 && bit_o == 4'h0) first = e;
      if (rise_o != 0) n_rise++;
      if (fall_o == 4'h5) n_fall++;
    end
    check_val("fall_latency", 32'(first), 32'd4);
    check_val("fall_fall_cnt", 32'(n_fall), 32'(EDGE_EN));
    check_val("fall_rise_cnt", 32'(n_rise), 32'd0);

    // 2-cycle glitch on channel 0 is dropped
    n_high = 0;
    n_rise = 0;
    for (int e = 0; e < 12; e++) begin
      cyc(e < 2 ? 4'h1 : 4'h0);
      if (bit_o[0]) n_high++;
      if (rise_o != 0 || fall_o != 0) n_rise++;
    end
    check_val("glitch_high", 32'(n_high), 32'd0);
    check_val("glitch_strobes", 32'(n_rise), 32'd0);

    // 3-cycle pulse on channel 0 passes with its width intact
    n_high = 0;
    n_rise = 0;
    n_fall = 0;
    for (int e = 0; e < 13; e++) begin
      cyc(e < 3 ? 4'h1 : 4'h0);
      if (bit_o[0]) n_high++;
      if (rise_o[0]) n_rise++;
      if (fall_o[0]) n_fall++;
    end
    check_val("pulse_high", 32'(n_high), 32'd3);
    check_val("pulse_rise_cnt", 32'(n_rise), 32'(EDGE_EN));
    check_val("pulse_fall_cnt", 32'(n_fall), 32'(EDGE_EN));

    // reset asserted just before acceptance of 4'hA
    for (int e = 0; e < 4; e++) cyc(4'hA);
    rst_i = 1'b1;
    #1;
    model_reset();
    check_val("mid_rst_bit", 32'(bit_o), 32'd0);
    check_val("mid_rst_rise", 32'(rise_o), 32'd0);
    check_val("mid_rst_fall", 32'(fall_o), 32'd0);
    check_val("mid_rst_chg", 32'(chg_o), 32'd0);
    for (int e = 0; e < 3; e++) cyc(4'hA);
    @(negedge clk_i);
    rst_i  = 1'b0;
    first  = -1;
    n_rise = 0;
    for (int e = 0; e < 10; e++) begin
      cyc(4'hA);
      if (first < 0 && bit_o == 4'hA) first = e;
      if (rise_o == 4'hA) n_rise++;
    end
    check_val("mid_rst_latency", 32'(first), 32'd4);
    check_val("mid_rst_rise_cnt", 32'(n_rise), 32'(EDGE_EN));

    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_sync_filt.md
# bit_sync_filt

Parametrised multi-channel successor to the single-bit synchroniser. Each of WIDTH asynchronous inputs passes through a STAGES-deep flop chain and then a per-channel persistence filter that rejects pulses shorter than FILT_CNT clock cycles. Optional one-cycle rise/fall strobes are produced per channel. Sits at the boundary between external or foreign-clock level signals and `clk_i`-domain control logic: buttons, status pins, slow handshake levels.

## Interface

- `WIDTH`, 1, number of independent channels (≥1)
- `STAGES`, 2, synchroniser flops per channel (≥2)
- `FILT_CNT`, 4, consecutive cycles a new level must persist before acceptance (≥1; 1 = no filtering)
- `INIT_VAL`, 1'b0, reset value of every sync stage and of every `bit_o` bit

- `clk_i` input 1 — sole clock
- `rst_i` input 1 — asynchronous, active-high reset; one clock, reset is asynchronous and active-high
- `bit_i` input WIDTH — asynchronous level inputs
- `bit_o` output WIDTH — synchronised, filtered levels
- `rise_o` output WIDTH — one-cycle strobe when `bit_o[n]` goes 0→1
- `fall_o` output WIDTH — one-cycle strobe when `bit_o[n]` goes 1→0
- `chg_o` output 1 — OR-reduction of `rise_o | fall_o`

## Operation

- Per channel n: chain `sync[0..STAGES-1]`; `sync[0] <= bit_i[n]`, `sync[k] <= sync[k-1]`. Let `s = sync[STAGES-1]`.
- Filter counter `cnt`, width `$clog2(FILT_CNT+1)`, reset 0.
  - `s == bit_o[n]`: `cnt <= 0`.
  - `s != bit_o[n]` and `cnt < FILT_CNT-1`: `cnt <= cnt+1`.
  - `s != bit_o[n]` and `cnt == FILT_CNT-1`: `bit_o[n] <= s`, `cnt <= 0`, assert `rise_o[n]` (if s=1) or `fall_o[n]` (if s=0) for that cycle only.
- Any cycle where `s` returns to `bit_o[n]` before acceptance clears `cnt`; no output change, no strobe.
- Channels fully independent; simultaneous transitions on several channels yield simultaneous strobes; `chg_o` high once.
- `rise_o`, `fall_o` registered; `chg_o` combinational OR of registered strobes.
- `rise_o[n]` and `fall_o[n]` never both high.
- Reset (any time, including mid-count): all sync stages and `bit_o` → INIT_VAL, `cnt` → 0, `rise_o`/`fall_o` → 0 immediately (asynchronous); `chg_o` → 0. Release is synchronous to the next edge; no strobe is generated by reset or its release.
- Input held at INIT_VAL through reset release: no output activity.

## Timing

- Edge 0 = first `clk_i` edge sampling the new stable level into `sync[0]`.
- `s` shows new level after edge STAGES-1.
- `bit_o` and strobe update after edge STAGES+FILT_CNT-1 (latency STAGES+FILT_CNT edges counting edge 0). Defaults: 6 edges; STAGES=2, FILT_CNT=1: 3 edges.
- Strobe high for exactly one cycle, coincident with the first cycle `bit_o` shows the new value.
- Minimum accepted pulse width at `s`: FILT_CNT cycles; shorter pulses are dropped entirely.
- Only `sync[0]` samples asynchronous data; `sync[0]` and `sync[1]` carry the metastability-flop attributes for placement.

## Configuration

- `BIT_SYNC_FILT_EDGE_EN` defined: edge-detect logic compiled in; `rise_o`, `fall_o`, `chg_o` behave as above.
- Not defined: edge logic removed; `rise_o`, `fall_o` tied to all-zero, `chg_o` tied 0; `bit_o` behaviour and latency unchanged.

## Test plan

Bench parameters WIDTH=4, STAGES=2, FILT_CNT=3, INIT_VAL=0, macro defined unless noted.

- Reset: `rst_i`=1, `bit_i`=4'hF for 10 cycles -> `bit_o`=4'h0, `rise_o`=`fall_o`=4'h0, `chg_o`=0 throughout; no strobe after release while `bit_i` returns to 4'h0.
- Step: `bit_i` 4'h0→4'h5 held -> `bit_o`=4'h5 after edge 4 (5 edges), `rise_o`=4'h5 and `chg_o`=1 for exactly one cycle, then 4'h0/0.
- Glitch: `bit_i[0]` high for 2 cycles, otherwise 0 -> `bit_o` stays 4'h0, no strobes; 3-cycle pulse -> `bit_o[0]` high 3 cycles, one rise and one fall strobe.
- Fall: `bit_i` 4'h5→4'h0 -> `bit_o`=4'h0 after 5 edges, `fall_o`=4'h5 one cycle, `rise_o`=0.
- Reset mid-count: `bit_i`=4'hA, assert `rst_i` after edge 3 -> all outputs 0 immediately; after release with `bit_i` held, `bit_o`=4'hA exactly 5 edges after release, single `rise_o`=4'hA.
- Macro undefined: repeat step/fall -> identical `bit_o` timing; `rise_o`, `fall_o`, `chg_o` constantly 0.
